// File: rtl/dmem_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dmem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_LD_HOLD
  } state_e;

  // Upper 24 address bits of the MMIO page that bypasses dMem.
  localparam logic [23:0] IO_PAGE = 24'hFFFFFC;

  function automatic logic is_io_page(input logic [23:0] page);
    return page == IO_PAGE;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle between the MEM stage, the UART loader, dMem and the arbiter.
// slave modport: arbiter side; master modport: requester/memory side.
interface dmem_access_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  logic              ld_mode;
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ld_mode, ld_req, ld_addr, ld_wdata,
    output ld_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ld_mode, ld_req, ld_addr, ld_wdata,
    input  ld_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_arbiter_perf.sv
// Performance counters for the dMem arbiter: CPU loads acked, CPU stores
// acked and stall cycles. 32-bit, wrapping, cleared by reset.
module dmem_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_evt_i,
  input  logic        wr_evt_i,
  input  logic        stall_evt_i,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
);
  logic [31:0] rd_q, wr_q, stall_q;

  // Event counters, one increment per flagged cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      stall_q <= '0;
    end else begin
      if (rd_evt_i)    rd_q    <= rd_q + 32'd1;
      if (wr_evt_i)    wr_q    <= wr_q + 32'd1;
      if (stall_evt_i) stall_q <= stall_q + 32'd1;
    end
  end

  assign rd_cnt_o    = rd_q;
  assign wr_cnt_o    = wr_q;
  assign stall_cnt_o = stall_q;
endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the synchronous dMem BRAM between the MEM stage and the UART loader,
// absorbs the 1-cycle read latency with a stall, and forces a loader grant
// after STARVE_MAX waiting cycles in run mode.
// Optional feature macro: DMEM_PERF_EN (adds perf_rd_cnt/perf_wr_cnt/perf_stall_cnt).
module dmem_access_arbiter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_access_arbiter_if.slave bus
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]          perf_rd_cnt,
  output logic [31:0]          perf_wr_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ld_ack_q, ld_ack_d;

  logic                mem_en, mem_we, cpu_stall, ld_grant;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  // State, starvation counter and registered responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
    end
  end

  // Grant selection, memory port drive and next state. Outputs are forced
  // low while reset is asserted so a reset mid-access is quiet immediately.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_stall   = 1'b0;
    ld_grant    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_CPU_RD: begin
          cpu_rdata_d = bus.mem_rdata;
          cpu_ack_d   = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_LD_HOLD: begin
          cpu_stall = bus.cpu_req;
          ld_grant  = bus.ld_req;
          if (!bus.ld_mode) state_d = ST_IDLE;
        end
        default: begin
          if (bus.ld_mode) begin
            cpu_stall = bus.cpu_req;
            ld_grant  = bus.ld_req;
            state_d   = ST_LD_HOLD;
          end else if (bus.ld_req && starve_q == STARVE_W'(STARVE_MAX)) begin
            cpu_stall = 1'b1;
            ld_grant  = 1'b1;
          end else if (bus.cpu_req && is_io_page(bus.cpu_addr[31:8])) begin
            cpu_ack_d = 1'b1;
          end else if (bus.cpu_req && bus.cpu_we) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = bus.cpu_addr[ADDR_W+1:2];
            mem_wdata = bus.cpu_wdata;
            cpu_ack_d = 1'b1;
          end else if (bus.cpu_req) begin
            mem_en    = 1'b1;
            mem_addr  = bus.cpu_addr[ADDR_W+1:2];
            cpu_stall = 1'b1;
            state_d   = ST_CPU_RD;
          end else if (bus.ld_req) begin
            ld_grant = 1'b1;
          end
        end
      endcase

      // Loader write overrides any CPU drive of the port in the same cycle
      if (ld_grant) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = bus.ld_addr[ADDR_W+1:2];
        mem_wdata = bus.ld_wdata;
        ld_ack_d  = 1'b1;
        starve_d  = '0;
      end else if (bus.ld_req && !bus.ld_mode && starve_q != STARVE_W'(STARVE_MAX)) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_stall = cpu_stall;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Byte-lane and out-of-range address bits are not used for word access
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[1:0], bus.ld_addr[1:0], bus.ld_addr[31:ADDR_W+2]};

`ifdef DMEM_PERF_EN
  logic rd_evt, wr_evt;
  assign rd_evt = cpu_ack_d & ((state_q == ST_CPU_RD) | ~bus.cpu_we);
  assign wr_evt = cpu_ack_d & (state_q != ST_CPU_RD) & bus.cpu_we;

  dmem_perf_cnt u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_evt_i    (rd_evt),
    .wr_evt_i    (wr_evt),
    .stall_evt_i (cpu_stall),
    .rd_cnt_o    (perf_rd_cnt),
    .wr_cnt_o    (perf_wr_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a behavioural 1-cycle BRAM.
module tb_dmem_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  dmem_access_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

`ifdef DMEM_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  dmem_access_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMEM_PERF_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous BRAM model, seeded on the first clock edge
  logic [31:0] ram [0:16383];
  logic [31:0] ram_q = '0;
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      ram[4]  <= 32'hA5A5A5A5;
      ram[8]  <= 32'h12345678;
      ram[16] <= 32'h0;
      seeded  <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    #1;
    chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd1);
    tick;
    chk({tag, "_ack_early"}, 32'(bus.cpu_ack), 32'd0);
    bus.cpu_req = 1'b0;
    tick;
    chk({tag, "_ack"}, 32'(bus.cpu_ack), 32'd1);
    chk({tag, "_data"}, bus.cpu_rdata, exp);
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_mode = 1'b0; bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;

    repeat (2) tick;
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    rst_n = 1'b1;
    tick;

    // Load 0x20: one stall cycle, ack + data two cycles after request
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    #1;
    chk("ld_stall", 32'(bus.cpu_stall), 32'd1);
    chk("ld_mem_en", 32'(bus.mem_en), 32'd1);
    chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
    chk("ld_mem_addr", 32'(bus.mem_addr), 32'd8);
    tick;
    chk("ld_stall_rd", 32'(bus.cpu_stall), 32'd0);
    chk("ld_ack_early", 32'(bus.cpu_ack), 32'd0);
    bus.cpu_req = 1'b0;
    tick;
    chk("ld_ack", 32'(bus.cpu_ack), 32'd1);
    chk("ld_rdata", bus.cpu_rdata, 32'h12345678);
    tick;
    chk("ld_ack_pulse", 32'(bus.cpu_ack), 32'd0);

    // Store 0xDEADBEEF to 0x24, no stall, then read back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h24; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("st_mem_we", 32'(bus.mem_we), 32'd1);
    chk("st_mem_en", 32'(bus.mem_en), 32'd1);
    chk("st_mem_addr", 32'(bus.mem_addr), 32'd9);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("st_stall", 32'(bus.cpu_stall), 32'd0);
    tick;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    chk("st_ack", 32'(bus.cpu_ack), 32'd1);
    do_load("st_rb", 32'h24, 32'hDEADBEEF);

    // MMIO load bypasses memory
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hFFFFFC70;
    #1;
    chk("io_mem_en", 32'(bus.mem_en), 32'd0);
    chk("io_stall", 32'(bus.cpu_stall), 32'd0);
    tick;
    bus.cpu_req = 1'b0;
    chk("io_ack", 32'(bus.cpu_ack), 32'd1);
    tick;
    chk("io_ack_pulse", 32'(bus.cpu_ack), 32'd0);

    // Loader session: four words while the CPU keeps requesting a store
    bus.ld_mode = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hBADBAD00;
    for (int i = 0; i < 4; i++) begin
      bus.ld_req = 1'b1; bus.ld_addr = 32'(i * 4); bus.ld_wdata = 32'hC0DE0000 + 32'(i);
      #1;
      chk("lm_stall", 32'(bus.cpu_stall), 32'd1);
      chk("lm_mem_addr", 32'(bus.mem_addr), 32'(i));
      chk("lm_mem_wdata", bus.mem_wdata, 32'hC0DE0000 + 32'(i));
      tick;
      chk("lm_ld_ack", 32'(bus.ld_ack), 32'd1);
      chk("lm_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    end
    bus.ld_req = 1'b0; bus.ld_mode = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick;
    chk("lm_ld_ack_end", 32'(bus.ld_ack), 32'd0);
    chk("lm_cpu_ack_end", 32'(bus.cpu_ack), 32'd0);
    for (int i = 0; i < 4; i++) do_load("lm_rb", 32'(i * 4), 32'hC0DE0000 + 32'(i));
    do_load("lm_cpu_blocked", 32'h40, 32'h0);

    // Starvation: continuous stores, loader held; forced grant on cycle 9
    bus.ld_req = 1'b1; bus.ld_addr = 32'h200; bus.ld_wdata = 32'h5A5A0001;
    bus.cpu_we = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100 + 32'(4 * c); bus.cpu_wdata = 32'(c);
      #1;
      chk("sv_stall", 32'(bus.cpu_stall), 32'd0);
      chk("sv_mem_addr", 32'(bus.mem_addr), 32'h40 + 32'(c));
      tick;
      chk("sv_cpu_ack", 32'(bus.cpu_ack), 32'd1);
      chk("sv_ld_ack", 32'(bus.ld_ack), 32'd0);
    end
    bus.cpu_addr = 32'h124; bus.cpu_wdata = 32'd9;
    #1;
    chk("sv_force_stall", 32'(bus.cpu_stall), 32'd1);
    chk("sv_force_addr", 32'(bus.mem_addr), 32'h80);
    chk("sv_force_wdata", bus.mem_wdata, 32'h5A5A0001);
    tick;
    chk("sv_force_ld_ack", 32'(bus.ld_ack), 32'd1);
    chk("sv_force_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    bus.ld_req = 1'b0;
    #1;
    chk("sv_retry_stall", 32'(bus.cpu_stall), 32'd0);
    chk("sv_retry_addr", 32'(bus.mem_addr), 32'h49);
    tick;
    chk("sv_retry_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    do_load("sv_rb_ld", 32'h200, 32'h5A5A0001);
    do_load("sv_rb_retry", 32'h124, 32'd9);
    do_load("sv_rb_first", 32'h104, 32'd1);

    // Reset in the middle of a read: quiet at once, no stale ack afterwards
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_stall", 32'(bus.cpu_stall), 32'd0);
    chk("mr_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mr_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("mr_rdata", bus.cpu_rdata, 32'd0);
    chk("mr_ld_ack", 32'(bus.ld_ack), 32'd0);
    bus.cpu_req = 1'b0;
    repeat (2) tick;
    chk("mr_no_ack_in_rst", 32'(bus.cpu_ack), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("mr_no_stale_ack", 32'(bus.cpu_ack), 32'd0);
    do_load("mr_load", 32'h10, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
